// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared entry types and helpers for the RAM port arbiter
package dpram_arb_pkg;
    localparam int ID_MAX_W   = 8;
    localparam int ADDR_MAX_W = 16;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } pipe_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] addr;
    } trk_entry_t;

    function automatic int rr_next(input int idx, input int n = 4);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick starting just after the last winner
module rr_arbiter import dpram_arb_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_WIDTH-1:0] idx
);
    logic [ID_WIDTH-1:0] k;

    // scan farthest-first so the requester nearest after ptr overwrites and wins
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ID_WIDTH'(rr_next(int'(ptr) + i, NUM_REQ));
            if (req[k]) begin
                gnt = NUM_REQ'(1) << k;
                idx = k;
            end
        end
    end
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one latency-RAM port with read-after-write protection
module dpram_port_arbiter import dpram_arb_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int WR_LATENCY = 1,
    parameter int RD_LATENCY = 1,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_rvalid,
    output logic [ID_WIDTH-1:0]           o_rid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_ram_en,
    output logic                          o_ram_we,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_din,
    input  logic [DATA_WIDTH-1:0]         i_ram_dout
);
    logic [ID_WIDTH-1:0]   ptr, win;
    logic [NUM_REQ-1:0]    elig;
    logic                  acc, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    trk_entry_t            trk  [WR_LATENCY+1];
    pipe_entry_t           pipe [RD_LATENCY+1];

    // a read is held back while any uncommitted write targets its address
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = i_req[k];
            for (int j = 0; j <= WR_LATENCY; j++)
                if (!i_we[k] && trk[j].valid && trk[j].addr == ADDR_MAX_W'(i_addr[k*ADDR_WIDTH +: ADDR_WIDTH]))
                    elig[k] = 1'b0;
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
        .req(elig),
        .ptr(ptr),
        .gnt(o_gnt),
        .idx(win)
    );

    assign acc = |o_gnt;

    // mux the winning requester's command fields
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (o_gnt[k]) begin
                sel_we   = i_we[k];
                sel_addr = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din  = i_din[k*DATA_WIDTH +: DATA_WIDTH];
            end
    end

    // issue the accepted command to the RAM port and remember the winner
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr        <= ID_WIDTH'(NUM_REQ - 1);
            o_ram_en   <= 1'b0;
            o_ram_we   <= 1'b0;
            o_ram_addr <= '0;
            o_ram_din  <= '0;
        end else begin
            o_ram_en <= acc;
            o_ram_we <= acc & sel_we;
            if (acc) begin
                ptr        <= win;
                o_ram_addr <= sel_addr;
                o_ram_din  <= sel_din;
            end
        end

    // hazard tracker: accepted writes age out once committed in the RAM
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int j = 0; j <= WR_LATENCY; j++) trk[j] <= '0;
        end else begin
            trk[0] <= '{valid: acc & sel_we, addr: ADDR_MAX_W'(sel_addr)};
            for (int j = 1; j <= WR_LATENCY; j++) trk[j] <= trk[j-1];
        end

    // read tag pipe aligned with RAM read latency
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int j = 0; j <= RD_LATENCY; j++) pipe[j] <= '0;
        end else begin
            pipe[0] <= '{valid: acc & ~sel_we, id: ID_MAX_W'(win)};
            for (int j = 1; j <= RD_LATENCY; j++) pipe[j] <= pipe[j-1];
        end

    // return read data tagged with its requester
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            o_rvalid <= 1'b0;
            o_rid    <= '0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= pipe[RD_LATENCY].valid;
            if (pipe[RD_LATENCY].valid) begin
                o_rid   <= ID_WIDTH'(pipe[RD_LATENCY].id);
                o_rdata <= i_ram_dout;
            end
        end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed checks of arbitration, hazards, read return and reset
module tb_dpram_port_arbiter;
    localparam int N = 4, DW = 8, AW = 4, IW = 2;
    localparam logic [3:0] EG3 [7] = '{4'd1, 4'd4, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};

    logic clk = 1'b0, rst = 1'b1, load = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req, we, gnt, req2, we2, gnt2;
    logic [N*AW-1:0] addr, addr2;
    logic [N*DW-1:0] din, din2;
    logic            rvalid, rvalid2, ram_en, ram_en2, ram_we, ram_we2;
    logic [IW-1:0]   rid, rid2;
    logic [DW-1:0]   rdata, rdata2, ram_din, ram_din2, ram_dout, ram_dout2;
    logic [AW-1:0]   ram_addr, ram_addr2;
    logic [7:0]      mem1 [16], mem2 [16], shadow [16];
    logic [7:0]      r0, r1, w_d;
    logic [3:0]      w_a;
    logic            w_v;
    int              n_err = 0, n_chk = 0;

    dpram_port_arbiter u_dut (
        .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_din(din),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rid(rid), .o_rdata(rdata),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_din(ram_din),
        .i_ram_dout(ram_dout)
    );

    dpram_port_arbiter #(.WR_LATENCY(2), .RD_LATENCY(3)) u_dut2 (
        .clk(clk), .rst(rst), .i_req(req2), .i_we(we2), .i_addr(addr2), .i_din(din2),
        .o_gnt(gnt2), .o_rvalid(rvalid2), .o_rid(rid2), .o_rdata(rdata2),
        .o_ram_en(ram_en2), .o_ram_we(ram_we2), .o_ram_addr(ram_addr2), .o_ram_din(ram_din2),
        .i_ram_dout(ram_dout2)
    );

    // RAM port with write latency 1 and read latency 1, preloaded mem[a]=a+0x10
    always @(posedge clk)
        if (load) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 8'(i + 16);
        end else if (ram_en) begin
            if (ram_we) mem1[ram_addr] <= ram_din;
            else ram_dout <= mem1[ram_addr];
        end

    // RAM port with write latency 2 and read latency 3, preloaded mem[a]=a
    always @(posedge clk)
        if (load) begin
            for (int i = 0; i < 16; i++) mem2[i] <= 8'(i);
            w_v <= 1'b0;
        end else begin
            w_v <= ram_en2 & ram_we2;
            w_a <= ram_addr2;
            w_d <= ram_din2;
            if (w_v) mem2[w_a] <= w_d;
            if (ram_en2 & !ram_we2) r0 <= mem2[ram_addr2];
            r1 <= r0;
            ram_dout2 <= r1;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] g;
        logic [7:0]   exp_r, wd;
        logic [3:0]   wa, ra;
        int           t_acc;
        bit           got;
        req = 0; we = 0; addr = 0; din = 0;
        req2 = 0; we2 = 0; addr2 = 0; din2 = 0;
        exp_r = 0;
        for (int i = 0; i < 16; i++) shadow[i] = 8'(i);
        repeat (2) @(posedge clk);
        #1 rst = 0; load = 0;

        // reset then idle
        chk("ptr_rst", u_dut.ptr, 3);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("idle", {gnt, rvalid, rid, rdata, ram_en, ram_we, ram_addr, ram_din}, 0);
        end
        chk("idle2", {gnt2, rvalid2, ram_en2, ram_we2}, 0);

        // four continuous readers: rotating grants, tagged data three cycles later
        @(posedge clk); #1;
        req = 4'hF; addr = {4'd3, 4'd2, 4'd1, 4'd0};
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("rr_gnt", gnt, 32'(1 << (t % 4)));
            chk("rr_rvalid", rvalid, t >= 3);
            if (t >= 3) begin
                chk("rr_rid", rid, (t - 3) % 4);
                chk("rr_rdata", rdata, 16 + (t - 3) % 4);
            end
        end
        @(posedge clk); #1 req = 0;
        repeat (4) @(posedge clk);

        // write addr5 vs blocked read addr5 and a free read addr6
        #1;
        req = 4'b0111; we = 4'b0001; addr = {4'd0, 4'd6, 4'd5, 4'd5}; din = {24'd0, 8'hA5};
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            chk("haz_gnt", gnt, EG3[t]);
            chk("haz_rvalid", rvalid, t == 4 || t == 6);
            if (t == 1) chk("haz_cmd", {ram_en, ram_we, ram_addr, ram_din}, {2'b11, 4'd5, 8'hA5});
            if (t == 4) chk("haz_r2", {rid, rdata}, {2'd2, 8'h16});
            if (t == 6) chk("haz_r1", {rid, rdata}, {2'd1, 8'hA5});
            g = gnt;
            @(posedge clk); #1 req = req & ~g;
        end

        // reset with two reads in flight
        req = 4'b0110; we = 0; addr = {4'd0, 4'd9, 4'd8, 4'd0};
        @(negedge clk); chk("rst_pre_g0", gnt, 4'b0100); g = gnt;
        @(posedge clk); #1 req = req & ~g;
        @(negedge clk); chk("rst_pre_g1", gnt, 4'b0010);
        @(posedge clk); #1 req = 0; rst = 1;
        @(negedge clk);
        chk("rst_en", {ram_en, rvalid}, 0);
        chk("rst_ptr", u_dut.ptr, 3);
        @(posedge clk); #1 rst = 0; req = 4'b1001; addr = {4'd3, 4'd0, 4'd0, 4'd2};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("rst_norv", rvalid, 0);
            if (t == 0) chk("rst_first", gnt, 4'b0001);
            if (t == 1) chk("rst_second", gnt, 4'b1000);
            g = gnt;
            @(posedge clk); #1 req = req & ~g;
        end
        req = 0;
        repeat (4) @(posedge clk);

        // single requester held for six cycles
        #1;
        req = 4'b0100; addr = {4'd0, 4'd7, 4'd0, 4'd0};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("single_gnt", gnt, 4'b0100);
            if (t >= 3) chk("single_rd", {rvalid, rid, rdata}, {1'b1, 2'd2, 8'h17});
        end
        @(posedge clk); #1 req = 0;
        @(negedge clk); chk("single_off", gnt, 0);

        // WR_LATENCY=2 / RD_LATENCY=3 scoreboard of write/read pairs
        for (int i = 0; i < 8; i++) begin
            wa = 4'($urandom_range(15));
            wd = 8'($urandom);
            ra = (i % 2 == 0) ? wa : 4'($urandom_range(15));
            @(posedge clk); #1;
            req2 = 4'b0011; we2 = 4'b0001; addr2 = {8'd0, ra, wa}; din2 = {24'd0, wd};
            got = 0; t_acc = -100;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (rvalid2) begin
                    got = 1;
                    chk("sb_data", rdata2, exp_r);
                    chk("sb_delay", t - t_acc, 5);
                    chk("sb_rid", rid2, 1);
                end
                g = gnt2 & req2;
                if (g[0]) shadow[wa] = wd;
                if (g[1]) begin
                    exp_r = shadow[ra];
                    t_acc = t;
                end
                @(posedge clk); #1 req2 = req2 & ~g;
            end
            chk("sb_done", got, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
